// File: rtl/atx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package atx_arb_pkg;

  localparam int unsigned NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DROP = 2'd2
  } atx_state_t;

endpackage

// File: rtl/atx_handshake.sv
// UART load/busy handshake FSM; ATX_ARB_TIMEOUT_EN adds an abort when
// atx_busy never acknowledges a load.
module atx_handshake
  import atx_arb_pkg::*;
#(
  parameter int unsigned BUSY_TIMEOUT = 1023,
  parameter int unsigned TO_W         = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  output logic load,
  output logic idle,
  output logic err
);

  atx_state_t state, state_next;
  logic       load_q, load_next;

  if ((64'd1 << TO_W) <= 64'(BUSY_TIMEOUT)) begin : g_bad_cfg
    $error("atx_handshake: TO_W too narrow for BUSY_TIMEOUT");
  end

`ifdef ATX_ARB_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_MATCH = TO_W'(BUSY_TIMEOUT);

  logic [TO_W-1:0] to_cnt;
  logic            err_q, err_next;
  logic            timeout;

  assign timeout = (state == LOAD) && (to_cnt == TO_MATCH);

  always_ff @(posedge clk) begin
    if (reset || start) begin
      to_cnt <= '0;
    end else if (state == LOAD) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`endif

  always_comb begin
    state_next = state;
`ifdef ATX_ARB_TIMEOUT_EN
    err_next   = 1'b0;
`endif
    unique case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        // acknowledge takes priority over a coincident timeout
        if (busy) begin
          state_next = DROP;
`ifdef ATX_ARB_TIMEOUT_EN
        end else if (timeout) begin
          state_next = IDLE;
          err_next   = 1'b1;
`endif
        end
      end
      DROP: if (!busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    load_next = (state_next == LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      load_q <= 1'b0;
    end else begin
      state  <= state_next;
      load_q <= load_next;
    end
  end

`ifdef ATX_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_next;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign load = load_q;
  assign idle = (state == IDLE);

endmodule

// File: rtl/atx_arbiter.sv
// Round-robin arbiter sharing the UART transmitter between CPU and debug
// sources; ATX_ARB_TIMEOUT_EN enables the load-abort timeout.
module atx_arbiter
  import atx_arb_pkg::*;
#(
  parameter int unsigned BUSY_TIMEOUT = 1023,
  parameter int unsigned TO_W         = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] atx_data,
  output logic       atx_load,
  input  logic       atx_busy,
  output logic       active,
  output logic       owner,
  output logic       err_timeout
);

  logic [NUM_REQ-1:0] grant, ready;
  logic [7:0]         data_q;
  logic               owner_q;
  logic               last;
  logic               idle;

  always_comb begin
    grant = '0;
    if (req0_valid && (!req1_valid || last)) begin
      grant[0] = 1'b1;
    end else if (req1_valid) begin
      grant[1] = 1'b1;
    end
  end

  assign ready = (idle && !atx_busy) ? grant : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      owner_q <= 1'b0;
      last    <= 1'b1;
    end else if (ready[0]) begin
      data_q  <= req0_data;
      owner_q <= 1'b0;
      last    <= 1'b0;
    end else if (ready[1]) begin
      data_q  <= req1_data;
      owner_q <= 1'b1;
      last    <= 1'b1;
    end
  end

  atx_handshake #(
    .BUSY_TIMEOUT (BUSY_TIMEOUT),
    .TO_W         (TO_W)
  ) u_handshake (
    .clk   (clk),
    .reset (reset),
    .start (|ready),
    .busy  (atx_busy),
    .load  (atx_load),
    .idle  (idle),
    .err   (err_timeout)
  );

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign atx_data   = data_q;
  assign owner      = owner_q;
  assign active     = !idle;

endmodule

// File: tb/tb_atx_arbiter.sv
// Directed self-checking bench for atx_arbiter with a small UART busy model.
module tb_atx_arbiter;

`ifdef ATX_ARB_TIMEOUT_EN
  localparam int unsigned TB_TO = 7;
`else
  localparam int unsigned TB_TO = 1023;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic [7:0] atx_data;
  logic       atx_load, atx_busy;
  logic       active, owner, err_timeout;

  int total = 0;
  int bad   = 0;

  int model_en  = 0;
  int ack_delay = 0;
  int busy_hold = 1;
  int busy_cnt  = 0;
  int load_age  = 0;
  int err_total = 0;

  always #5 clk = ~clk;

  atx_arbiter #(
    .BUSY_TIMEOUT (TB_TO),
    .TO_W         (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .atx_data    (atx_data),
    .atx_load    (atx_load),
    .atx_busy    (atx_busy),
    .active      (active),
    .owner       (owner),
    .err_timeout (err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART model: busy rises ack_delay cycles after load rises, stays busy_hold cycles
  task automatic tick();
    @(posedge clk);
    #1;
    if (err_timeout) err_total++;
    if (model_en != 0) begin
      if (busy_cnt > 0) busy_cnt--;
      if (busy_cnt == 0 && atx_load) begin
        if (load_age == ack_delay) busy_cnt = busy_hold;
        load_age++;
      end else begin
        load_age = 0;
      end
      atx_busy = (busy_cnt > 0);
    end else begin
      busy_cnt = 0;
      load_age = 0;
    end
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ready_cnt, load_cnt, idle_at, n, multi, rdy, nrise, run, lmax;
    logic prev_load;
    logic [7:0] seq_data [4];
    logic       seq_own  [4];
    int         rises    [3];

    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    atx_busy = 1'b0;
    settle(2);
    reset = 1'b0;
    #1;
    check("rst_load", atx_load, 0);
    check("rst_active", active, 0);
    check("rst_data", atx_data, 8'h00);
    check("rst_owner", owner, 0);
    check("rst_err", err_timeout, 0);

    // single byte, busy 2 cycles after load for 10 cycles
    model_en = 1; ack_delay = 2; busy_hold = 10;
    req0_valid = 1'b1; req0_data = 8'h55;
    #1;
    ready_cnt = int'(req0_ready);
    load_cnt = 0; idle_at = -1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      ready_cnt += int'(req0_ready);
      load_cnt  += int'(atx_load);
      if (!active && idle_at < 0) idle_at = i;
      if (i == 1) begin
        check("single_data", atx_data, 8'h55);
        check("single_owner", owner, 0);
        check("single_active", active, 1);
      end
      if (i == 13) req0_valid = 1'b0;
    end
    check("single_ready_cycles", ready_cnt, 1);
    check("single_load_cycles", load_cnt, 3);
    check("single_idle_cycle", idle_at, 14);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_data", atx_data, 8'h00);

    // contention with fast acknowledge
    ack_delay = 0; busy_hold = 1;
    req0_valid = 1'b1; req0_data = 8'h41;
    req1_valid = 1'b1; req1_data = 8'h42;
    #1;
    n = 0; multi = 0; prev_load = 1'b0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      tick();
      if (req0_ready && req1_ready) multi++;
      if (atx_load && !prev_load) begin
        seq_data[n] = atx_data;
        seq_own[n]  = owner;
        n++;
      end
      prev_load = atx_load;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("cont_count", n, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("cont_data%0d", k), seq_data[k], (k % 2 == 0) ? 8'h41 : 8'h42);
      check($sformatf("cont_owner%0d", k), seq_own[k], k % 2);
    end
    check("cont_one_ready", multi, 0);
    settle(8);

    // busy already high at idle; req0 pulses valid and withdraws
    model_en = 0;
    atx_busy = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h0D;
    rdy = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin req0_valid = 1'b1; req0_data = 8'h99; end
      if (i == 8) req0_valid = 1'b0;
      #1;
      rdy += int'(req0_ready || req1_ready);
      tick();
    end
    check("busy_idle_ready", rdy, 0);
    check("busy_idle_data", atx_data, 8'h42);
    check("busy_idle_active", active, 0);
    atx_busy = 1'b0;
    #1;
    check("busy_fall_ready1", req1_ready, 1);
    check("busy_fall_ready0", req0_ready, 0);
    tick();
    req1_valid = 1'b0;
    check("busy_fall_data", atx_data, 8'h0D);
    check("busy_fall_owner", owner, 1);
    check("busy_fall_load", atx_load, 1);
    model_en = 1; ack_delay = 0; busy_hold = 1;
    settle(6);

    // immediate acknowledge: 1-cycle load, 3-cycle occupancy
    req0_valid = 1'b1; req0_data = 8'h33;
    #1;
    nrise = 0; run = 0; lmax = 0; prev_load = 1'b0;
    for (int i = 0; i < 30 && nrise < 3; i++) begin
      tick();
      run = atx_load ? run + 1 : 0;
      if (run > lmax) lmax = run;
      if (atx_load && !prev_load) begin
        rises[nrise] = i;
        nrise++;
      end
      prev_load = atx_load;
    end
    req0_valid = 1'b0;
    check("imm_count", nrise, 3);
    check("imm_gap1", rises[1] - rises[0], 3);
    check("imm_gap2", rises[2] - rises[1], 3);
    check("imm_load_len", lmax, 1);
    settle(6);

    // reset while atx_load is high
    model_en = 0; atx_busy = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h77;
    #1;
    tick();
    check("rstl_load_before", atx_load, 1);
    reset = 1'b1;
    req0_data = 8'h41;
    req1_valid = 1'b1; req1_data = 8'h42;
    tick();
    check("rstl_load", atx_load, 0);
    check("rstl_active", active, 0);
    check("rstl_data", atx_data, 8'h00);
    reset = 1'b0;
    #1;
    check("rstl_ready0", req0_ready, 1);
    check("rstl_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rstl_owner", owner, 0);
    check("rstl_next_data", atx_data, 8'h41);
    model_en = 1;
    settle(6);

`ifdef ATX_ARB_TIMEOUT_EN
    // busy never rises: abort after BUSY_TIMEOUT+1 load cycles
    model_en = 0; atx_busy = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h5A;
    #1;
    tick();
    req0_valid = 1'b0;
    n = 0; idle_at = -1;
    for (int i = 1; i <= 14; i++) begin
      if (err_timeout) begin
        n++;
        if (idle_at < 0) begin
          idle_at = i;
          check("to_load_at_err", atx_load, 0);
        end
      end
      tick();
    end
    check("to_pulses", n, 1);
    check("to_cycle", idle_at, 9);
    req1_valid = 1'b1; req1_data = 8'h66;
    #1;
    check("to_next_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    check("to_next_data", atx_data, 8'h66);
    check("to_next_load", atx_load, 1);
    model_en = 1;
    settle(6);
    check("err_total", err_total, 1);
`else
    // without timeout the load waits indefinitely
    model_en = 0; atx_busy = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h5A;
    #1;
    tick();
    req0_valid = 1'b0;
    settle(30);
    check("wait_load", atx_load, 1);
    check("wait_active", active, 1);
    model_en = 1;
    settle(6);
    check("wait_done", active, 0);
    check("err_total", err_total, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atx_arbiter.md
# atx_arbiter

Shares the single UART transmitter between two byte sources, the CPU's output-word port and a hardware debug/monitor source. It takes over the atx_data/atx_load/atx_busy handshake that software otherwise performs by polling:
- wait for the UART to be idle;
- present the byte and raise atx_load;
- hold atx_load until atx_busy acknowledges;
- release.

It sits between the requesters and the UART transmitter, in the same clock domain as the core.

## Interface
- BUSY_TIMEOUT, default 1023: cycles to wait in LOAD for atx_busy before aborting. Used only with the timeout feature.
- TO_W, default 10: width of the timeout counter. Must satisfy 2^TO_W > BUSY_TIMEOUT.
- clk  in  1  core clock. Single clock domain.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 (CPU) has a byte.
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  requester 0 byte accepted this cycle.
- req1_valid  in  1  requester 1 (debug/monitor) has a byte.
- req1_data  in  8  requester 1 byte.
- req1_ready  out  1  requester 1 byte accepted this cycle.
- atx_data  out  8  byte to the UART transmitter.
- atx_load  out  1  load strobe to the UART, held until acknowledged.
- atx_busy  in  1  UART transmitter busy.
- active  out  1  a byte is in flight (state is not IDLE).
- owner  out  1  index of the requester that owns the in-flight byte.
- err_timeout  out  1  one-cycle pulse when a load is aborted.

## Operation
- States:
  - IDLE: may accept a new byte.
  - LOAD: atx_load is high; waiting for atx_busy to go high.
  - DROP: atx_load is low; waiting for atx_busy to go low.
- Grant is round-robin using register `last`:
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester other than `last` is granted.
- reqK_ready = (state==IDLE) && !atx_busy && grantK. This is combinational; at most one ready is high in any cycle.
- Transfer happens on the clock edge where valid && ready. On that edge:
  - atx_data <= the granted byte.
  - owner <= K and last <= K.
  - state <= LOAD.
- LOAD:
  - atx_load = 1.
  - When atx_busy is sampled as 1: state <= DROP, atx_load <= 0.
- DROP:
  - When atx_busy is sampled as 0: state <= IDLE.
- atx_data is held stable from the transfer edge until the next transfer.
- Reset values:
  - state = IDLE, atx_load = 0, atx_data = 0x00.
  - active = 0, owner = 0, err_timeout = 0.
  - last = 1, so requester 0 wins the first contention.
- Boundary cases:
  - atx_busy already high in IDLE: no ready is asserted; requesters stall.
  - A requester drops valid before it is granted: nothing is accepted and no state changes.
  - Both requesters valid on every cycle: grants alternate 0, 1, 0, 1, and so on.
  - Reset in LOAD or DROP: state returns to IDLE and atx_load = 0 on the next edge. The in-flight byte is lost and no ready is re-issued for it.

## Timing
- Cycle 0: IDLE, valid and ready are both high; the transfer occurs on this edge.
- Cycle 1: LOAD, atx_load = 1 and atx_data = byte.
- atx_busy is sampled every cycle in LOAD. If it is 1 at cycle n, atx_load = 0 from cycle n+1.
- Minimum occupancy is 3 cycles per byte: accept, then LOAD for 1 cycle, then DROP for at least 1 cycle.
- The next accept can occur in the first IDLE cycle in which atx_busy = 0.
- All outputs except reqK_ready are registered.

## Configuration
- ATX_ARB_TIMEOUT_EN defined:
  - A TO_W-bit counter clears on entry to LOAD and increments each LOAD cycle.
  - When it equals BUSY_TIMEOUT while atx_busy = 0, then on that edge: state <= IDLE, atx_load <= 0, and err_timeout pulses for one cycle. The byte is dropped.
  - If atx_busy = 1 in the same cycle as the count match, the acknowledge wins and the FSM goes to DROP.
- ATX_ARB_TIMEOUT_EN undefined:
  - LOAD waits indefinitely.
  - err_timeout is tied to 0 and there is no counter logic.

## Structure
- Package atx_arb_pkg holds the state enum (IDLE, LOAD, DROP) and the requester-count constant NUM_REQ = 2.
- Sub-module atx_handshake holds the LOAD/DROP FSM and the optional timeout. Its interface:
  - Inputs: start, busy.
  - Outputs: load, idle, err.
- The top level holds the round-robin grant, the data/owner registers and the ready logic.

## Test plan
- Single byte: req0 sends 0x55, and the UART model raises busy 2 cycles after load then drops it 10 cycles later.
  - Expect req0_ready for 1 cycle and atx_data = 0x55.
  - Expect atx_load high for exactly 3 cycles.
  - Expect active low again 1 cycle after busy falls.
- Contention: both requesters valid continuously, req0 sending 0x41 and req1 sending 0x42.
  - Expect atx_data sequence 0x41, 0x42, 0x41, 0x42.
  - Expect owner to alternate 0, 1, 0, 1.
- Busy at idle: hold atx_busy = 1 for 20 cycles while req1 presents 0x0D.
  - Expect no ready during those 20 cycles.
  - Expect acceptance in the first cycle after busy falls.
- Immediate acknowledge: busy goes high in the same cycle load rises. Expect load high for 1 cycle and 3-cycle occupancy per byte.
- Reset mid-LOAD: assert reset while atx_load = 1.
  - Expect atx_load = 0, active = 0 and atx_data = 0x00 after the next edge.
  - Expect req0 to win the next contention.
- With ATX_ARB_TIMEOUT_EN and BUSY_TIMEOUT = 7, busy never rises.
  - Expect err_timeout to pulse once, 8 cycles after load rises.
  - Expect atx_load low and the next byte accepted.
